// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - IO-region load/store decode, cycle/retire counters,
// UART RX buffer FIFO and one-entry UART TX holding register.
module mmio_ctrl #(
  parameter int unsigned RX_DEPTH = 4,
  parameter logic [31:0] IO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_s2,
  input  logic [31:0] wdata_s2,
  input  logic        load_s2,
  input  logic        store_s2,
  input  logic        flush_s2,
  input  logic        retire_s3,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  output logic        uart_rx_valid_s3,
  output logic        uart_tx_ready_s3,
  output logic [7:0]  uart_rx_out_s3,
  output logic [31:0] cyc_counter,
  output logic [31:0] instr_counter
);
  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(RX_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [2:0] OFF_RX_DATA = 3'd1;
  localparam logic [2:0] OFF_TX_DATA = 3'd2;
  localparam logic [2:0] OFF_CNT_RST = 3'd6;

  logic [7:0]    rx_mem [RX_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   rx_count;
  logic          tx_full;
  logic [2:0]    offset;
  logic          io_hit, rx_empty, rx_full, rx_pop, rx_push;
  logic          tx_store, tx_accept, tx_drain, cnt_clear;
  logic          unused_bits;

  // Only the word index within the region matters; upper offset bits alias.
  assign offset    = addr_s2[4:2];
  assign io_hit    = (addr_s2[31:30] == IO_BASE[31:30]) && !flush_s2;
  assign rx_empty  = (rx_count == '0);
  assign rx_full   = (rx_count == FULL_CNT);
  assign rx_pop    = io_hit && load_s2 && (offset == OFF_RX_DATA) && !rx_empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take a byte.
  assign rx_push   = uart_rx_data_out_valid && (!rx_full || rx_pop);
  assign tx_store  = io_hit && store_s2 && (offset == OFF_TX_DATA);
  assign tx_drain  = tx_full && uart_tx_data_in_ready;
  assign tx_accept = tx_store && (!tx_full || uart_tx_data_in_ready);
  assign cnt_clear = io_hit && store_s2 && (offset == OFF_CNT_RST);

  assign uart_rx_data_out_ready = !rx_full;
  assign uart_tx_data_in_valid  = tx_full;
  assign unused_bits = ^{addr_s2[29:5], addr_s2[1:0], wdata_s2[31:8], IO_BASE[29:0]};

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr] <= uart_rx_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (rx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
      else if (rx_pop && !rx_push) rx_count <= rx_count - CNT_ONE;
    end
  end

  // Stage-3 view lags by one cycle to line up with the memory read path.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_rx_valid_s3 <= 1'b0;
      uart_tx_ready_s3 <= 1'b1;
      uart_rx_out_s3   <= 8'h00;
    end else begin
      uart_rx_valid_s3 <= !rx_empty;
      uart_tx_ready_s3 <= !tx_full;
      uart_rx_out_s3   <= rx_pop ? rx_mem[rd_ptr] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_full         <= 1'b0;
      uart_tx_data_in <= 8'h00;
    end else if (tx_accept) begin
      tx_full         <= 1'b1;
      uart_tx_data_in <= wdata_s2[7:0];
    end else if (tx_drain) begin
      tx_full         <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cyc_counter   <= 32'd0;
      instr_counter <= 32'd0;
    end else begin
      cyc_counter <= cyc_counter + 32'd1;
      if (retire_s3) instr_counter <= instr_counter + 32'd1;
    end
  end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - self-checking bench for mmio_ctrl: vector table,
// directed corner sequences and random traffic against a queue-based model.
module tb_mmio_ctrl;
  localparam int RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_s2, wdata_s2;
  logic        load_s2, store_s2, flush_s2, retire_s3;
  logic [7:0]  rx_d;
  logic        rx_v, rx_rdy;
  logic [7:0]  tx_d;
  logic        tx_v, tx_rdy;
  logic        rxv3, txr3;
  logic [7:0]  rxo3;
  logic [31:0] cyc, ins;

  mmio_ctrl #(.RX_DEPTH(RX_DEPTH), .IO_BASE(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .addr_s2(addr_s2), .wdata_s2(wdata_s2),
    .load_s2(load_s2), .store_s2(store_s2), .flush_s2(flush_s2), .retire_s3(retire_s3),
    .uart_rx_data_out(rx_d), .uart_rx_data_out_valid(rx_v), .uart_rx_data_out_ready(rx_rdy),
    .uart_tx_data_in(tx_d), .uart_tx_data_in_valid(tx_v), .uart_tx_data_in_ready(tx_rdy),
    .uart_rx_valid_s3(rxv3), .uart_tx_ready_s3(txr3), .uart_rx_out_s3(rxo3),
    .cyc_counter(cyc), .instr_counter(ins)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: FIFO as a queue, TX slot as a flag plus byte.
  logic [7:0]  mq[$];
  bit          m_txf;
  logic [7:0]  m_txb;
  logic [31:0] m_cyc, m_ins;
  logic        m_rxv3, m_txr3;
  logic [7:0]  m_rxo3;

  typedef struct {
    logic [31:0] addr;
    logic        ld;
    logic [7:0]  rxd;
    logic        rxv;
    logic [7:0]  e_out;
    logic        e_v3;
    logic        e_rdy;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit hit, pop, push;
    int off;
    off = int'(addr_s2[4:2]);
    hit = (addr_s2[31:30] == 2'b10) && !flush_s2;
    if (rst) begin
      mq.delete();
      m_txf = 0; m_txb = 8'h00; m_cyc = 0; m_ins = 0;
      m_rxv3 = 0; m_txr3 = 1; m_rxo3 = 8'h00;
      return;
    end
    pop  = hit && load_s2 && off == 1 && mq.size() > 0;
    push = rx_v && (mq.size() < RX_DEPTH || pop);
    m_rxv3 = mq.size() > 0;
    m_txr3 = !m_txf;
    m_rxo3 = pop ? mq[0] : 8'h00;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(rx_d);
    if (hit && store_s2 && off == 2 && (!m_txf || tx_rdy)) begin
      m_txf = 1; m_txb = wdata_s2[7:0];
    end else if (m_txf && tx_rdy) begin
      m_txf = 0;
    end
    if (hit && store_s2 && off == 6) begin
      m_cyc = 0; m_ins = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (retire_s3) m_ins = m_ins + 1;
    end
  endtask

  task automatic idle();
    rst = 0; addr_s2 = 0; wdata_s2 = 0; load_s2 = 0; store_s2 = 0;
    flush_s2 = 0; retire_s3 = 0; rx_d = 0; rx_v = 0; tx_rdy = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    chk("rx_ready", {31'b0, rx_rdy}, {31'b0, mq.size() < RX_DEPTH});
    chk("tx_valid", {31'b0, tx_v}, {31'b0, m_txf});
    chk("tx_data", {24'b0, tx_d}, {24'b0, m_txb});
    chk("rx_valid_s3", {31'b0, rxv3}, {31'b0, m_rxv3});
    chk("tx_ready_s3", {31'b0, txr3}, {31'b0, m_txr3});
    chk("rx_out_s3", {24'b0, rxo3}, {24'b0, m_rxo3});
    chk("cyc_counter", cyc, m_cyc);
    chk("instr_counter", ins, m_ins);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] c0;
    tbl[0] = '{32'h0, 0, 8'h41, 1, 8'h00, 0, 1};
    tbl[1] = '{32'h0, 0, 8'h42, 1, 8'h00, 1, 1};
    tbl[2] = '{32'h0, 0, 8'h43, 1, 8'h00, 1, 1};
    tbl[3] = '{32'h0, 0, 8'h44, 1, 8'h00, 1, 0};
    tbl[4] = '{32'h8000_0004, 1, 8'h00, 0, 8'h41, 1, 1};
    tbl[5] = '{32'h8000_0004, 1, 8'h00, 0, 8'h42, 1, 1};
    tbl[6] = '{32'h8000_0004, 1, 8'h00, 0, 8'h43, 1, 1};
    tbl[7] = '{32'h8000_0004, 1, 8'h00, 0, 8'h44, 1, 1};
    tbl[8] = '{32'h8000_0004, 1, 8'h00, 0, 8'h00, 0, 1};

    idle(); rst = 1;
    tick(); tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    chk("idle_cyc", cyc, 32'd10);
    chk("idle_instr", ins, 32'd0);
    chk("idle_tx_ready_s3", {31'b0, txr3}, 32'd1);
    chk("idle_rx_valid_s3", {31'b0, rxv3}, 32'd0);
    chk("idle_rx_ready", {31'b0, rx_rdy}, 32'd1);

    foreach (tbl[i]) begin
      idle();
      addr_s2 = tbl[i].addr; load_s2 = tbl[i].ld; rx_d = tbl[i].rxd; rx_v = tbl[i].rxv;
      tick();
      chk($sformatf("tbl%0d_out", i), {24'b0, rxo3}, {24'b0, tbl[i].e_out});
      chk($sformatf("tbl%0d_v3", i), {31'b0, rxv3}, {31'b0, tbl[i].e_v3});
      chk($sformatf("tbl%0d_rdy", i), {31'b0, rx_rdy}, {31'b0, tbl[i].e_rdy});
    end

    // Full FIFO: push and pop together keeps it full and appends the new byte.
    for (int i = 0; i < 4; i++) begin
      idle(); rx_v = 1; rx_d = 8'h11 + 8'(i); tick();
    end
    idle(); addr_s2 = 32'h8000_0004; load_s2 = 1; rx_v = 1; rx_d = 8'h55; tick();
    chk("full_pp_out", {24'b0, rxo3}, 32'h11);
    chk("full_pp_rdy", {31'b0, rx_rdy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 3) ? 8'h55 : 8'h12 + 8'(i);
      idle(); addr_s2 = 32'h8000_0004; load_s2 = 1; tick();
      chk($sformatf("full_drain%0d", i), {24'b0, rxo3}, {24'b0, exp_b});
    end

    // TX handshake.
    idle(); addr_s2 = 32'h8000_0008; store_s2 = 1; wdata_s2 = 32'h1234_565A; tick();
    chk("tx_first_valid", {31'b0, tx_v}, 32'd1);
    chk("tx_first_data", {24'b0, tx_d}, 32'h5A);
    idle(); addr_s2 = 32'h8000_0008; store_s2 = 1; wdata_s2 = 32'h33; tick();
    chk("tx_dropped_data", {24'b0, tx_d}, 32'h5A);
    idle(); addr_s2 = 32'h8000_0008; store_s2 = 1; wdata_s2 = 32'h33; tx_rdy = 1; tick();
    chk("tx_refill_data", {24'b0, tx_d}, 32'h33);
    chk("tx_refill_valid", {31'b0, tx_v}, 32'd1);
    idle(); tx_rdy = 1; tick();
    chk("tx_drain_valid", {31'b0, tx_v}, 32'd0);
    idle(); tick();
    chk("tx_ready_s3_after", {31'b0, txr3}, 32'd1);

    // Counter clear beats same-cycle increments, then counting resumes.
    idle(); addr_s2 = 32'h8000_0018; store_s2 = 1; retire_s3 = 1; tick();
    chk("clr_cyc", cyc, 32'd0);
    chk("clr_instr", ins, 32'd0);
    idle(); retire_s3 = 1; tick();
    chk("clr_cyc_next", cyc, 32'd1);
    chk("clr_instr_next", ins, 32'd1);

    force dut.cyc_counter = 32'hFFFF_FFFF;
    #1 release dut.cyc_counter;
    m_cyc = 32'hFFFF_FFFF;
    idle(); tick();
    chk("cyc_wrap", cyc, 32'd0);

    // Flushed accesses have no side effects.
    idle(); rx_v = 1; rx_d = 8'h77; tick();
    idle(); addr_s2 = 32'h8000_0004; load_s2 = 1; flush_s2 = 1; tick();
    chk("flush_no_pop", {24'b0, rxo3}, 32'h0);
    idle(); addr_s2 = 32'h8000_0008; store_s2 = 1; wdata_s2 = 32'h99; flush_s2 = 1; tick();
    chk("flush_no_tx", {31'b0, tx_v}, 32'd0);
    c0 = cyc;
    idle(); addr_s2 = 32'h8000_0018; store_s2 = 1; flush_s2 = 1; tick();
    chk("flush_no_clr", cyc, c0 + 32'd1);
    idle(); addr_s2 = 32'h8000_0004; load_s2 = 1; tick();
    chk("flush_byte_kept", {24'b0, rxo3}, 32'h77);

    // Reset mid-transfer overrides every other event.
    idle(); rx_v = 1; rx_d = 8'hA1; tick();
    idle(); rx_v = 1; rx_d = 8'hA2; tick();
    idle(); addr_s2 = 32'h8000_0008; store_s2 = 1; wdata_s2 = 32'hB0; tick();
    idle(); rst = 1; addr_s2 = 32'h8000_0004; load_s2 = 1; rx_v = 1; rx_d = 8'hC3; retire_s3 = 1; tick();
    chk("rst_rx_ready", {31'b0, rx_rdy}, 32'd1);
    chk("rst_tx_valid", {31'b0, tx_v}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_d}, 32'd0);
    chk("rst_rx_valid_s3", {31'b0, rxv3}, 32'd0);
    chk("rst_tx_ready_s3", {31'b0, txr3}, 32'd1);
    chk("rst_rx_out_s3", {24'b0, rxo3}, 32'd0);
    chk("rst_cyc", cyc, 32'd0);
    chk("rst_instr", ins, 32'd0);

    for (int i = 0; i < 400; i++) begin
      int kind;
      idle();
      kind = int'($urandom_range(0, 3));
      addr_s2 = {(kind == 0) ? 2'($urandom) : 2'b10, 25'($urandom), 3'($urandom_range(0, 7)), 2'b00};
      case ($urandom_range(0, 2))
        0: load_s2 = 1;
        1: store_s2 = 1;
        default: ;
      endcase
      wdata_s2  = $urandom;
      flush_s2  = ($urandom_range(0, 7) == 0);
      retire_s3 = 1'($urandom);
      rx_v      = 1'($urandom);
      rx_d      = 8'($urandom);
      tx_rdy    = 1'($urandom);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
